// File: rtl/csi_parser.sv
`default_nettype none
// ============================================================================
// Module   : csi_parser
// Purpose  : ESC / CSI control-sequence parser; one decoded command per
//            sequence over a valid/ready handshake. Optional macro
//            CSI_PRIVATE_EN enables the '?' private-marker flag.
// Revision : 1.0 - initial release
// ============================================================================
module csi_parser #(
  parameter int MAX_PARAMS = 4,
  parameter int PARAM_W    = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [7:0]                      in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic                            cmd_valid,
  input  logic                            cmd_ready,
  output logic [4:0]                      cmd_type,
  output logic [MAX_PARAMS*PARAM_W-1:0]   cmd_params,
  output logic [$clog2(MAX_PARAMS+1)-1:0] cmd_nparams,
  output logic [7:0]                      cmd_char,
  output logic                            cmd_private,
  output logic [1:0]                      state_dbg
);

  localparam int                 c_NP_W     = $clog2(MAX_PARAMS+1);
  localparam int                 c_IDX_W    = (MAX_PARAMS > 1) ? $clog2(MAX_PARAMS) : 1;
  localparam logic [PARAM_W-1:0] c_SAT      = {PARAM_W{1'b1}};
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(MAX_PARAMS-1);

  typedef enum logic [1:0] {
    ST_GROUND = 2'd0,
    ST_ESC    = 2'd1,
    ST_CSI    = 2'd2,
    ST_IGNORE = 2'd3
  } state_t;

  state_t             r_state;
  logic [PARAM_W-1:0] r_slot [MAX_PARAMS];
  logic [c_IDX_W-1:0] r_idx;
  logic               r_seen;
  logic               r_drop;
`ifdef CSI_PRIVATE_EN
  logic               r_priv;
`endif

  logic               w_accept, w_c0, w_cancel, w_digit, w_semi, w_quest, w_final, w_inter;
  logic               w_esc_hit, w_fin_hit;
  logic [4:0]         w_esc_type, w_fin_type;
  logic [PARAM_W+3:0] w_acc;
  logic [PARAM_W-1:0] w_digit_val;

  assign in_ready  = ~cmd_valid;
  assign state_dbg = r_state;
  assign w_accept  = in_valid & ~cmd_valid;
  assign w_c0      = (in_data < 8'h20);
  assign w_cancel  = (in_data == 8'h18) | (in_data == 8'h1A);
  assign w_digit   = (in_data >= 8'h30) & (in_data <= 8'h39);
  assign w_semi    = (in_data == 8'h3B);
  assign w_quest   = (in_data == 8'h3F);
  assign w_final   = (in_data >= 8'h40) & (in_data <= 8'h7E);
  assign w_inter   = (in_data >= 8'h20) & (in_data <= 8'h2F);

  // slot*10 + digit; four headroom bits hold 10*max+9 so saturation is exact.
  assign w_acc       = ({4'd0, r_slot[r_idx]} << 3) + ({4'd0, r_slot[r_idx]} << 1)
                     + {{PARAM_W{1'b0}}, in_data[3:0]};
  assign w_digit_val = (w_acc > {4'd0, c_SAT}) ? c_SAT : w_acc[PARAM_W-1:0];

  always_comb begin
    w_esc_hit  = 1'b1;
    w_esc_type = 5'd0;
    case (in_data)
      8'h44:   w_esc_type = 5'd1;
      8'h45:   w_esc_type = 5'd2;
      8'h4D:   w_esc_type = 5'd3;
      8'h37:   w_esc_type = 5'd14;
      8'h38:   w_esc_type = 5'd15;
      8'h63:   w_esc_type = 5'd16;
      default: w_esc_hit  = 1'b0;
    endcase
  end

  always_comb begin
    w_fin_hit  = 1'b1;
    w_fin_type = 5'd0;
    case (in_data)
      8'h41:        w_fin_type = 5'd4;
      8'h42:        w_fin_type = 5'd5;
      8'h43:        w_fin_type = 5'd6;
      8'h44:        w_fin_type = 5'd7;
      8'h48, 8'h66: w_fin_type = 5'd8;
      8'h4A:        w_fin_type = 5'd9;
      8'h4B:        w_fin_type = 5'd10;
      8'h6D:        w_fin_type = 5'd11;
      8'h68:        w_fin_type = 5'd12;
      8'h6C:        w_fin_type = 5'd13;
      default:      w_fin_hit  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_GROUND;
      r_idx       <= '0;
      r_seen      <= 1'b0;
      r_drop      <= 1'b0;
      for (int i = 0; i < MAX_PARAMS; i++) r_slot[i] <= '0;
      cmd_valid   <= 1'b0;
      cmd_type    <= 5'd0;
      cmd_params  <= '0;
      cmd_nparams <= '0;
      cmd_char    <= 8'd0;
`ifdef CSI_PRIVATE_EN
      r_priv      <= 1'b0;
      cmd_private <= 1'b0;
`endif
    end else begin
      if (cmd_valid && cmd_ready) cmd_valid <= 1'b0;
      if (w_accept) begin
        // Inside a sequence C0 bytes never reach the per-state decode.
        if (r_state != ST_GROUND && w_c0) begin
          if (w_cancel)              r_state <= ST_GROUND;
          else if (in_data == 8'h1B) r_state <= ST_ESC;
        end else begin
          case (r_state)
            ST_GROUND: begin
              if (in_data == 8'h1B) begin
                r_state <= ST_ESC;
              end else begin
                cmd_valid   <= 1'b1;
                cmd_type    <= 5'd0;
                cmd_char    <= in_data;
                cmd_params  <= '0;
                cmd_nparams <= '0;
`ifdef CSI_PRIVATE_EN
                cmd_private <= 1'b0;
`endif
              end
            end
            ST_ESC: begin
              r_state <= ST_GROUND;
              if (w_esc_hit) begin
                cmd_valid   <= 1'b1;
                cmd_type    <= w_esc_type;
                cmd_char    <= in_data;
                cmd_params  <= '0;
                cmd_nparams <= '0;
`ifdef CSI_PRIVATE_EN
                cmd_private <= 1'b0;
`endif
              end else if (in_data == 8'h5B) begin
                r_state <= ST_CSI;
                r_idx   <= '0;
                r_seen  <= 1'b0;
                r_drop  <= 1'b0;
                for (int i = 0; i < MAX_PARAMS; i++) r_slot[i] <= '0;
`ifdef CSI_PRIVATE_EN
                r_priv  <= 1'b0;
`endif
              end
            end
            ST_CSI: begin
              if (w_digit) begin
                r_seen <= 1'b1;
                if (!r_drop) r_slot[r_idx] <= w_digit_val;
              end else if (w_semi) begin
                r_seen <= 1'b1;
                if (r_idx == c_LAST_IDX) r_drop <= 1'b1;
                else                     r_idx  <= r_idx + c_IDX_W'(1);
              end else if (w_quest) begin
`ifdef CSI_PRIVATE_EN
                if (!r_seen) r_priv  <= 1'b1;
                else         r_state <= ST_IGNORE;
`else
                r_state <= ST_IGNORE;
`endif
              end else if (w_final) begin
                r_state <= ST_GROUND;
                if (w_fin_hit) begin
                  cmd_valid   <= 1'b1;
                  cmd_type    <= w_fin_type;
                  cmd_char    <= in_data;
                  cmd_nparams <= r_seen ? (c_NP_W'(r_idx) + c_NP_W'(1)) : '0;
                  for (int i = 0; i < MAX_PARAMS; i++)
                    cmd_params[i*PARAM_W +: PARAM_W] <= r_slot[i];
`ifdef CSI_PRIVATE_EN
                  cmd_private <= r_priv;
`endif
                end
              end else if (w_inter) begin
                r_state <= ST_IGNORE;
              end
            end
            ST_IGNORE: begin
              if (w_final) r_state <= ST_GROUND;
            end
            default: r_state <= ST_GROUND;
          endcase
        end
      end
    end
  end

`ifndef CSI_PRIVATE_EN
  assign cmd_private = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_csi_parser.sv
`default_nettype none
// Bench for csi_parser: vector table, directed multi-cycle sequences and random
// traffic checked against a sequence-level reference model (two parameter sets).
module tb_csi_parser;
  localparam int PW = 8;
  localparam int M1 = 4;
  localparam int M2 = 2;
  localparam int T_TEXT = 0, T_ESC = 1, T_CSI = 2, T_SKIP = 3;

  typedef struct packed {
    logic [4:0]        typ;
    logic [7:0]        ch;
    logic [4:0]        np;
    logic              priv;
    logic [15:0][15:0] p;
  } cmd_t;

  typedef struct packed {
    logic [95:0] seq;
    logic [3:0]  len;
    logic        has;
    cmd_t        e;
  } vec_t;

  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, cmd_ready = 1'b1;
  logic [7:0] in_data = 8'd0;
  logic in_ready1, cmd_valid1, cmd_private1, in_ready2, cmd_valid2, cmd_private2;
  logic [4:0] cmd_type1, cmd_type2;
  logic [M1*PW-1:0] cmd_params1;
  logic [M2*PW-1:0] cmd_params2;
  logic [2:0] cmd_nparams1;
  logic [1:0] cmd_nparams2;
  logic [7:0] cmd_char1, cmd_char2;
  logic [1:0] state_dbg1, state_dbg2;

  csi_parser #(.MAX_PARAMS(M1), .PARAM_W(PW)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready1),
    .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready), .cmd_type(cmd_type1),
    .cmd_params(cmd_params1), .cmd_nparams(cmd_nparams1), .cmd_char(cmd_char1),
    .cmd_private(cmd_private1), .state_dbg(state_dbg1));

  csi_parser #(.MAX_PARAMS(M2), .PARAM_W(PW)) dut2 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready2),
    .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready), .cmd_type(cmd_type2),
    .cmd_params(cmd_params2), .cmd_nparams(cmd_nparams2), .cmd_char(cmd_char2),
    .cmd_private(cmd_private2), .state_dbg(state_dbg2));

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int ready_mode = 0;
  cmd_t got1[$], got2[$], exp1[$], exp2[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int md = T_TEXT;
  bit mpriv = 1'b0;
  logic [7:0] fld_q[$];

  function automatic int fin_type(input logic [7:0] b);
    case (b)
      8'h41: return 4;   8'h42: return 5;   8'h43: return 6;   8'h44: return 7;
      8'h48: return 8;   8'h66: return 8;   8'h4A: return 9;   8'h4B: return 10;
      8'h6D: return 11;  8'h68: return 12;  8'h6C: return 13;
      default: return -1;
    endcase
  endfunction

  function automatic cmd_t simple(input int t, input logic [7:0] ch);
    cmd_t c = '0;
    c.typ = 5'(t);
    c.ch  = ch;
    return c;
  endfunction

  function automatic cmd_t parse(input int m, input int t, input logic [7:0] ch);
    cmd_t c = '0;
    int f = 0;
    int nsemi = 0;
    int sat = (1 << PW) - 1;
    int vals[16] = '{default: 0};
    foreach (fld_q[k]) begin
      if (fld_q[k] == 8'h3B) begin
        f++;
        nsemi++;
      end else if (f < m) begin
        vals[f] = vals[f] * 10 + int'(fld_q[k] - 8'h30);
        if (vals[f] > sat) vals[f] = sat;
      end
    end
    c.typ  = 5'(t);
    c.ch   = ch;
    c.priv = mpriv;
    c.np   = (fld_q.size() == 0) ? 5'd0 : 5'((nsemi + 1 < m) ? nsemi + 1 : m);
    for (int i = 0; i < m; i++) c.p[i] = 16'(vals[i]);
    return c;
  endfunction

  function automatic void model_step(input logic [7:0] b);
    int t;
    if (md != T_TEXT && b < 8'h20) begin
      if (b == 8'h18 || b == 8'h1A) md = T_TEXT;
      else if (b == 8'h1B)          md = T_ESC;
      return;
    end
    case (md)
      T_TEXT: begin
        if (b == 8'h1B) md = T_ESC;
        else begin exp1.push_back(simple(0, b)); exp2.push_back(simple(0, b)); end
      end
      T_ESC: begin
        md = T_TEXT;
        t = (b == 8'h44) ? 1 : (b == 8'h45) ? 2 : (b == 8'h4D) ? 3 :
            (b == 8'h37) ? 14 : (b == 8'h38) ? 15 : (b == 8'h63) ? 16 : -1;
        if (t >= 0) begin exp1.push_back(simple(t, b)); exp2.push_back(simple(t, b)); end
        else if (b == 8'h5B) begin md = T_CSI; fld_q.delete(); mpriv = 1'b0; end
      end
      T_CSI: begin
        if ((b >= 8'h30 && b <= 8'h39) || b == 8'h3B) fld_q.push_back(b);
        else if (b == 8'h3F) begin
`ifdef CSI_PRIVATE_EN
          if (fld_q.size() == 0) mpriv = 1'b1; else md = T_SKIP;
`else
          md = T_SKIP;
`endif
        end else if (b >= 8'h20 && b <= 8'h2F) md = T_SKIP;
        else if (b >= 8'h40 && b <= 8'h7E) begin
          md = T_TEXT;
          t = fin_type(b);
          if (t >= 0) begin exp1.push_back(parse(M1, t, b)); exp2.push_back(parse(M2, t, b)); end
        end
      end
      default: if (b >= 8'h40 && b <= 8'h7E) md = T_TEXT;
    endcase
  endfunction

  function automatic void model_reset();
    md = T_TEXT;
    mpriv = 1'b0;
    fld_q.delete();
    exp1.delete();
    exp2.delete();
  endfunction

  // ---------------- capture / compare ----------------
  function automatic cmd_t cap1();
    cmd_t c = '0;
    c.typ = cmd_type1; c.ch = cmd_char1; c.np = 5'(cmd_nparams1); c.priv = cmd_private1;
    for (int i = 0; i < M1; i++) c.p[i] = 16'(cmd_params1[i*PW +: PW]);
    return c;
  endfunction

  function automatic cmd_t cap2();
    cmd_t c = '0;
    c.typ = cmd_type2; c.ch = cmd_char2; c.np = 5'(cmd_nparams2); c.priv = cmd_private2;
    for (int i = 0; i < M2; i++) c.p[i] = 16'(cmd_params2[i*PW +: PW]);
    return c;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (cmd_valid1 && cmd_ready) got1.push_back(cap1());
      if (cmd_valid2 && cmd_ready) got2.push_back(cap2());
      chk("in_ready1_vs_valid", int'(in_ready1), int'(!cmd_valid1));
      chk("in_ready2_vs_valid", int'(in_ready2), int'(!cmd_valid2));
    end
  end

  always @(posedge clk) begin
    #1;
    cmd_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  task automatic cmp_cmd(input string tag, input cmd_t a, input cmd_t e, input int m);
    chk({tag, ".type"}, int'(a.typ), int'(e.typ));
    if (e.typ == 5'd0) chk({tag, ".char"}, int'(a.ch), int'(e.ch));
    if (e.typ >= 5'd4 && e.typ <= 5'd13) begin
      chk({tag, ".char"}, int'(a.ch), int'(e.ch));
      chk({tag, ".nparams"}, int'(a.np), int'(e.np));
      chk({tag, ".private"}, int'(a.priv), int'(e.priv));
      for (int i = 0; i < m; i++) chk($sformatf("%s.param%0d", tag, i), int'(a.p[i]), int'(e.p[i]));
    end
  endtask

  task automatic check_queues(input string tag);
    chk({tag, ".count_m4"}, got1.size(), exp1.size());
    for (int k = 0; k < got1.size() && k < exp1.size(); k++) cmp_cmd({tag, ".m4"}, got1[k], exp1[k], M1);
    chk({tag, ".count_m2"}, got2.size(), exp2.size());
    for (int k = 0; k < got2.size() && k < exp2.size(); k++) cmp_cmd({tag, ".m2"}, got2[k], exp2[k], M2);
    got1.delete(); got2.delete(); exp1.delete(); exp2.delete();
  endtask

  // ---------------- drivers ----------------
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready1 && n < 200) begin @(negedge clk); n++; end
    if (!in_ready1) chk("in_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    model_step(b);
  endtask

  task automatic send_seq(input logic [95:0] s, input int len);
    for (int k = 0; k < len; k++) send_byte(s[8*(len-1-k) +: 8]);
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    while (cmd_valid1 && n < 300) begin @(negedge clk); n++; end
    if (cmd_valid1) chk("drain_timeout", 1, 0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rand_byte();
    string fins = "ABCDHfJKmhl";
    string escs = "DEM78c";
    int r = $urandom_range(0, 99);
    if (r < 12) return 8'h1B;
    if (r < 22) return 8'h5B;
    if (r < 48) return 8'(8'h30 + $urandom_range(0, 9));
    if (r < 58) return 8'h3B;
    if (r < 72) return fins[$urandom_range(0, 10)];
    if (r < 77) return escs[$urandom_range(0, 5)];
    if (r < 80) return 8'h3F;
    if (r < 82) return 8'h18;
    if (r < 85) return 8'($urandom_range(0, 31));
    if (r < 88) return 8'(8'h20 + $urandom_range(0, 15));
    return 8'($urandom_range(8'h40, 8'h7E));
  endfunction

  function automatic cmd_t mk(input int t, input logic [7:0] ch, input int np, input bit pv,
                              input int p0, input int p1, input int p2, input int p3);
    cmd_t c = '0;
    c.typ = 5'(t); c.ch = ch; c.np = 5'(np); c.priv = pv;
    c.p[0] = 16'(p0); c.p[1] = 16'(p1); c.p[2] = 16'(p2); c.p[3] = 16'(p3);
    return c;
  endfunction

  function automatic vec_t mkv(input logic [95:0] s, input int len, input bit has, input cmd_t e);
    vec_t v;
    v.seq = s; v.len = 4'(len); v.has = has; v.e = e;
    return v;
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t tbl[16];

  initial begin
    tbl[0]  = mkv(96'h1B5B31323B333448, 8, 1, mk(8, 8'h48, 2, 0, 12, 34, 0, 0));
    tbl[1]  = mkv(96'h1B5B39393939_41, 7, 1, mk(4, 8'h41, 1, 0, 255, 0, 0, 0));
    tbl[2]  = mkv(96'h1B5B6D, 3, 1, mk(11, 8'h6D, 0, 0, 0, 0, 0, 0));
    tbl[3]  = mkv(96'h1B5B353B3B3742, 7, 1, mk(5, 8'h42, 3, 0, 5, 0, 7, 0));
    tbl[4]  = mkv(96'h1B5B313B323B333B343B356D, 12, 1, mk(11, 8'h6D, 4, 0, 1, 2, 3, 4));
    tbl[5]  = mkv(96'h1B5B351878, 5, 1, mk(0, 8'h78, 0, 0, 0, 0, 0, 0));
    tbl[6]  = mkv(96'h1B37, 2, 1, mk(14, 8'h37, 0, 0, 0, 0, 0, 0));
    tbl[7]  = mkv(96'h1B63, 2, 1, mk(16, 8'h63, 0, 0, 0, 0, 0, 0));
`ifdef CSI_PRIVATE_EN
    tbl[8]  = mkv(96'h1B5B3F32356C, 6, 1, mk(13, 8'h6C, 1, 1, 25, 0, 0, 0));
`else
    tbl[8]  = mkv(96'h1B5B3F32356C, 6, 0, mk(0, 8'h00, 0, 0, 0, 0, 0, 0));
`endif
    tbl[9]  = mkv(96'h1B5B3120326D, 6, 0, mk(0, 8'h00, 0, 0, 0, 0, 0, 0));
    tbl[10] = mkv(96'h1B5B325A, 4, 0, mk(0, 8'h00, 0, 0, 0, 0, 0, 0));
    tbl[11] = mkv(96'h1B5B07334B, 5, 1, mk(10, 8'h4B, 1, 0, 3, 0, 0, 0));
    tbl[12] = mkv(96'h1B45, 2, 1, mk(2, 8'h45, 0, 0, 0, 0, 0, 0));
    tbl[13] = mkv(96'h1B5B1B5B3266, 6, 1, mk(8, 8'h66, 1, 0, 2, 0, 0, 0));
    tbl[14] = mkv(96'h1B5B3B48, 4, 1, mk(8, 8'h48, 2, 0, 0, 0, 0, 0));
    tbl[15] = mkv(96'h1B5B363535333643, 8, 1, mk(6, 8'h43, 1, 0, 255, 0, 0, 0));

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.state_dbg", int'(state_dbg1), 0);
    chk("rst.state_dbg2", int'(state_dbg2), 0);
    chk("rst.in_ready", int'(in_ready1), 1);
    chk("rst.cmd_valid", int'(cmd_valid1), 0);
    chk("rst.cmd_type", int'(cmd_type1), 0);
    chk("rst.cmd_params", int'(cmd_params1), 0);
    chk("rst.cmd_nparams", int'(cmd_nparams1), 0);
    chk("rst.cmd_char", int'(cmd_char1), 0);
    chk("rst.cmd_private", int'(cmd_private1), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // vector table, cmd_ready held high
    for (int v = 0; v < 16; v++) begin
      send_seq(tbl[v].seq, int'(tbl[v].len));
      drain();
      chk($sformatf("tbl%0d.count", v), got1.size(), int'(tbl[v].has));
      if (tbl[v].has && got1.size() > 0) cmp_cmd($sformatf("tbl%0d", v), got1[0], tbl[v].e, M1);
      check_queues($sformatf("tbl%0d.model", v));
    end

    // command held while cmd_ready is low for 5 cycles
    ready_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    send_byte(8'h41);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold.cmd_valid", int'(cmd_valid1), 1);
      chk("hold.in_ready", int'(in_ready1), 0);
      chk("hold.cmd_char", int'(cmd_char1), 8'h41);
    end
    ready_mode = 0;
    drain();
    check_queues("hold");

    // reset mid-sequence, after a CSI command left non-zero outputs
    send_seq(96'h1B5B373B396D, 6);
    drain();
    check_queues("pre_rst");
    send_seq(96'h1B5B33, 3);
    #2 rst = 1'b1;
    #1;
    chk("arst.state_dbg", int'(state_dbg1), 0);
    chk("arst.in_ready", int'(in_ready1), 1);
    chk("arst.cmd_params", int'(cmd_params1), 0);
    chk("arst.cmd_nparams", int'(cmd_nparams1), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    send_byte(8'h4B);
    drain();
    check_queues("post_rst");

    // reset discards a pending command
    ready_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    send_byte(8'h5A);
    @(negedge clk);
    chk("pend.cmd_valid", int'(cmd_valid1), 1);
    #1 rst = 1'b1;
    #1;
    chk("pend_rst.cmd_valid", int'(cmd_valid1), 0);
    chk("pend_rst.cmd_char", int'(cmd_char1), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    ready_mode = 0;
    model_reset();
    drain();
    check_queues("pend_rst");

    // randomized traffic with random backpressure
    ready_mode = 1;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 7) == 0) begin @(posedge clk); #1; end
      send_byte(rand_byte());
      if (i % 250 == 249) begin
        drain();
        check_queues("rand");
      end
    end
    ready_mode = 0;
    drain();
    check_queues("rand_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
